dmem_wait_responder: RTL and testbench

DMEM_WAIT_RESPONDER -- requirements
Module: dmem_wait_responder

---
 rtl/dmem_wait_responder.sv | 174 +++++++++++++++++
 tb/tb_dmem_wait_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// Wait-state data-memory responder: word RAM plus one MMIO result register.
// Optional build macro DMEM_MISALIGN_ERR_EN flags and drops misaligned accesses.
module dmem_wait_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_req,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_write_data,
    output logic [31:0] dmem_read_data,
    output logic        dmem_ready,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic        addr_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic [31:0] result_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] acc_addr_s;
    logic        acc_write_s;
    logic [31:0] rdata_d;
    logic        ram_we_s;

    function automatic logic is_ram(input logic [31:0] a);
        return ({1'b0, a} < RAM_BYTES);
    endfunction

    function automatic logic is_mmio(input logic [31:0] a);
        return (a[31:2] == MMIO_ADDR[31:2]);
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a);
`ifdef DMEM_MISALIGN_ERR_EN
        return (a[1:0] != 2'b00);
`else
        return (a[1:0] == 2'b00) && 1'b0;
`endif
    endfunction

    // Decode the in-flight access; in IDLE the live inputs are used so a
    // zero-wait access can produce its load data on the accepting edge.
    always_comb begin
        acc_addr_s  = addr_q;
        acc_write_s = write_q;
        rdata_d     = 32'd0;
        if (state_q == S_IDLE) begin
            acc_addr_s  = dmem_addr;
            acc_write_s = dmem_write;
        end else begin
            acc_addr_s  = addr_q;
            acc_write_s = write_q;
        end
        if (acc_write_s || is_misaligned(acc_addr_s)) begin
            rdata_d = 32'd0;
        end else if (is_mmio(acc_addr_s)) begin
            rdata_d = result_q;
        end else if (is_ram(acc_addr_s)) begin
            rdata_d = mem_q[acc_addr_s[AW+1:2]];
        end else begin
            rdata_d = 32'd0;
        end
    end

    // RAM store enable, valid only on the RESP edge of an aligned in-range store.
    always_comb begin
        ram_we_s = 1'b0;
        if ((state_q == S_RESP) && write_q && reset_n &&
            !is_misaligned(addr_q) && !is_mmio(addr_q) && is_ram(addr_q)) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // RAM array: deliberately not reset so contents survive reset_n.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[addr_q[AW+1:2]] <= wdata_q;
        end
    end

    // Access FSM with registered handshake, read data and result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (dmem_req) begin
                        write_q <= dmem_write;
                        addr_q  <= dmem_addr;
                        wdata_q <= dmem_write_data;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            cnt_q   <= 4'd0;
                            ready_q <= 1'b1;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LD;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        rdata_q <= rdata_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    if (is_misaligned(addr_q)) begin
                        err_q <= 1'b1;
                    end else if (write_q && is_mmio(addr_q)) begin
                        result_q <= wdata_q;
                        rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_ready     = ready_q;
    assign dmem_read_data = rdata_q;
    assign result_valid   = rvalid_q;
    assign result_data    = result_q;
`ifdef DMEM_MISALIGN_ERR_EN
    assign addr_err       = err_q;
`else
    assign addr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: load data expected at request
// time is queued and compared when dmem_ready pulses.
module tb_dmem_wait_responder;

    localparam int          W    = 2;
    localparam logic [31:0] MMIO = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_write = 1'b0;
    logic [31:0] dmem_addr = 32'd0;
    logic [31:0] dmem_write_data = 32'd0;
    logic [31:0] dmem_read_data;
    logic        dmem_ready;
    logic        result_valid;
    logic [31:0] result_data;
    logic        addr_err;

    always #5 clk = ~clk;

    dmem_wait_responder #(
        .DEPTH_WORDS (64),
        .WAIT_CYCLES (W),
        .MMIO_ADDR   (MMIO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .dmem_req        (dmem_req),
        .dmem_write      (dmem_write),
        .dmem_addr       (dmem_addr),
        .dmem_write_data (dmem_write_data),
        .dmem_read_data  (dmem_read_data),
        .dmem_ready      (dmem_ready),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .addr_err        (addr_err)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl [64];
    logic [31:0] res_m  = 32'd0;
    logic        resv_m = 1'b0;
    logic        err_m  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic misal(input logic [31:0] a);
`ifdef DMEM_MISALIGN_ERR_EN
        return (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        if (misal(a))                   return 32'd0;
        else if (a[31:2] == MMIO[31:2]) return res_m;
        else if (a < 32'd256)           return mdl[a[7:2]];
        else                            return 32'd0;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        if (misal(a)) begin
            err_m = 1'b1;
        end else if (a[31:2] == MMIO[31:2]) begin
            res_m  = d;
            resv_m = 1'b1;
        end else if (a < 32'd256) begin
            mdl[a[7:2]] = d;
        end
    endtask

    // Response monitor: pop the scoreboard on every ready pulse, else data must be 0.
    always @(negedge clk) begin
        if (dmem_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check_eq("rdata", dmem_read_data, exp_q.pop_front());
            end
        end else begin
            check_eq("rdata_idle", dmem_read_data, 32'd0);
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
        int lat;
        @(negedge clk);
        exp_q.push_back(wr ? 32'd0 : model_load(a));
        dmem_req = 1'b1; dmem_write = wr; dmem_addr = a; dmem_write_data = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!dmem_ready) begin
                dmem_write = ~wr; dmem_addr = $urandom; dmem_write_data = $urandom;
            end
        end while (!dmem_ready && lat < 20);
        check_eq({tag, "_lat"}, 32'(lat), 32'(W + 1));
        dmem_req = 1'b0; dmem_addr = $urandom; dmem_write_data = $urandom;
        if (wr) model_store(a, d);
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_rvalid"}, {31'd0, result_valid}, {31'd0, resv_m});
        check_eq({tag, "_rdata"}, result_data, res_m);
        check_eq({tag, "_err"}, {31'd0, addr_err}, {31'd0, err_m});
    endtask

    initial begin
        int gap;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, dmem_ready}, 32'd0);
        check_flags("rst");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_ready", {31'd0, dmem_ready}, 32'd0);
            check_flags("idle");
        end

        for (int i = 0; i < 64; i++) access(1'b1, 32'(i * 4), $urandom, "fill");
        access(1'b1, 32'h0000_00FC, 32'hCAFE_F00D, "st_last");
        access(1'b1, 32'h0000_0100, 32'h0BAD_0BAD, "st_beyond");
        access(1'b0, 32'h0000_00FC, 32'd0, "ld_last");
        access(1'b0, 32'h0000_0100, 32'd0, "ld_beyond");
        access(1'b0, 32'h0000_0000, 32'd0, "ld_w0_alias");

        access(1'b1, 32'h0000_0014, 32'd7, "st_14");
        access(1'b0, 32'h0000_0014, 32'd0, "ld_14");
        check_eq("ld_14_model", model_load(32'h14), 32'd7);

        access(1'b1, MMIO, 32'd32514, "st_mmio");
        check_flags("mmio");
        check_eq("mmio_value", result_data, 32'd32514);
        access(1'b0, 32'h0000_0000, 32'd0, "ld_w0");
        access(1'b0, MMIO, 32'd0, "ld_mmio");

        access(1'b0, 32'h0000_1000, 32'd0, "ld_oor");
        access(1'b1, 32'h0000_1000, 32'h1234_5678, "st_oor");
        for (int i = 0; i < 16; i++) access(1'b0, 32'(i * 4), 32'd0, "ld_chk");

        @(negedge clk);
        exp_q.push_back(model_load(32'h14));
        exp_q.push_back(model_load(32'h14));
        dmem_req = 1'b1; dmem_write = 1'b0; dmem_addr = 32'h14;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!dmem_ready && gap < 20);
        check_eq("b2b_first", 32'(gap), 32'(W + 1));
        gap = 0;
        do begin @(negedge clk); gap++; end while (!dmem_ready && gap < 20);
        check_eq("b2b_gap", 32'(gap), 32'(W + 2));
        dmem_req = 1'b0;
        @(negedge clk);

        access(1'b1, 32'h0000_0020, 32'h1111_2222, "st_20");
        @(negedge clk);
        exp_q.push_back(32'd0);
        dmem_req = 1'b1; dmem_write = 1'b1; dmem_addr = 32'h20; dmem_write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_ready", {31'd0, dmem_ready}, 32'd0);
        check_eq("async_rdata", dmem_read_data, 32'd0);
        check_eq("async_rvalid", {31'd0, result_valid}, 32'd0);
        check_eq("async_result", result_data, 32'd0);
        dmem_req = 1'b0;
        exp_q.delete();
        res_m = 32'd0; resv_m = 1'b0; err_m = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        access(1'b0, 32'h0000_0020, 32'd0, "ld_20_abort");
        check_eq("abort_model", model_load(32'h20), 32'h1111_2222);

        access(1'b1, 32'h0000_0020, 32'hAAAA_0000, "st_20b");
        access(1'b1, 32'h0000_0022, 32'h0000_0055, "st_22");
        check_flags("misal");
        access(1'b0, 32'h0000_0020, 32'd0, "ld_20b");
        access(1'b0, 32'h0000_0022, 32'd0, "ld_22");

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
